// File: rtl/fsm_pkg.sv
// Shared types for the serial front end: serializer state encoding and the
// line level driven on ser_out between frames.
package fsm_pkg;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'b00,
    SER_SHIFT = 2'b01,
    SER_PAR   = 2'b10
  } ser_state_t;

  localparam logic SER_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a word over valid/ready and shifts it out one bit per clk.
// Optional even-parity trailer bit enabled by defining PIPE_PARITY_BIT_EN.
module piso_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  ser_state_t       state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s, cnt_inc_s;
  logic             ser_out_r, ser_out_s;
  logic             ser_valid_r, ser_valid_s;
  logic             done_r, done_s;
  logic             load_ready_s;
  logic             accept_s;
  logic             last_bit_s;
  logic             front_s;
  logic             load_first_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] load_rest_s;
`ifdef PIPE_PARITY_BIT_EN
  logic             par_r, par_s;
`endif

  assign last_bit_s = (cnt_r == CNT_LAST);
  assign cnt_inc_s  = cnt_r + CNT_ONE;
  assign accept_s   = load_valid & load_ready_s;

  assign load_ready = load_ready_s;
  assign ser_out    = ser_out_r;
  assign ser_valid  = ser_valid_r;
  assign done       = done_r;

  // State, datapath and output registers; clr aborts any frame in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r     <= SER_IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      ser_out_r   <= SER_IDLE_LEVEL;
      ser_valid_r <= 1'b0;
      done_r      <= 1'b0;
`ifdef PIPE_PARITY_BIT_EN
      par_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      cnt_r       <= cnt_s;
      ser_out_r   <= ser_out_s;
      ser_valid_r <= ser_valid_s;
      done_r      <= done_s;
`ifdef PIPE_PARITY_BIT_EN
      par_r       <= par_s;
`endif
    end
  end

  // Ready depends only on state and count so the sender never sees a loop through valid.
  always_comb begin
    load_ready_s = 1'b0;
    case (state_r)
      SER_IDLE:  load_ready_s = 1'b1;
`ifdef PIPE_PARITY_BIT_EN
      SER_SHIFT: load_ready_s = 1'b0;
      SER_PAR:   load_ready_s = 1'b1;
`else
      SER_SHIFT: load_ready_s = last_bit_s;
      SER_PAR:   load_ready_s = 1'b0;
`endif
      default:   load_ready_s = 1'b0;
    endcase
  end

  // Bit-order selection: the shift register always keeps the next bit to send at its front.
  always_comb begin
    if (MSB_FIRST) begin
      front_s      = shreg_r[WIDTH-1];
      shifted_s    = {shreg_r[WIDTH-2:0], 1'b0};
      load_first_s = load_data[WIDTH-1];
      load_rest_s  = {load_data[WIDTH-2:0], 1'b0};
    end else begin
      front_s      = shreg_r[0];
      shifted_s    = {1'b0, shreg_r[WIDTH-1:1]};
      load_first_s = load_data[0];
      load_rest_s  = {1'b0, load_data[WIDTH-1:1]};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SER_IDLE: begin
        if (accept_s) state_s = SER_SHIFT;
        else          state_s = SER_IDLE;
      end
      SER_SHIFT: begin
        if (!last_bit_s)   state_s = SER_SHIFT;
        else if (accept_s) state_s = SER_SHIFT;
        else begin
`ifdef PIPE_PARITY_BIT_EN
          state_s = SER_PAR;
`else
          state_s = SER_IDLE;
`endif
        end
      end
      SER_PAR: begin
        if (accept_s) state_s = SER_SHIFT;
        else          state_s = SER_IDLE;
      end
      default: state_s = SER_IDLE;
    endcase
  end

  // Output/datapath logic: computes the bit shown next cycle, so ser_out leaves a flop.
  always_comb begin
    shreg_s     = shreg_r;
    cnt_s       = cnt_r;
    ser_out_s   = SER_IDLE_LEVEL;
    ser_valid_s = 1'b0;
    done_s      = 1'b0;
`ifdef PIPE_PARITY_BIT_EN
    par_s       = par_r;
`endif
    if (accept_s) begin
      shreg_s     = load_rest_s;
      cnt_s       = {CW{1'b0}};
      ser_out_s   = load_first_s;
      ser_valid_s = 1'b1;
`ifdef PIPE_PARITY_BIT_EN
      par_s       = load_first_s;
`endif
    end else if ((state_r == SER_SHIFT) && !last_bit_s) begin
      shreg_s     = shifted_s;
      cnt_s       = cnt_inc_s;
      ser_out_s   = front_s;
      ser_valid_s = 1'b1;
`ifdef PIPE_PARITY_BIT_EN
      par_s       = par_r ^ front_s;
`else
      done_s      = (cnt_inc_s == CNT_LAST);
`endif
    end else if (state_r == SER_SHIFT) begin
`ifdef PIPE_PARITY_BIT_EN
      ser_out_s   = par_r;
      ser_valid_s = 1'b1;
      done_s      = 1'b1;
`else
      ser_valid_s = 1'b0;
`endif
    end else begin
      ser_valid_s = 1'b0;
    end
  end

endmodule
